// File: rtl/nios_fprint_ocimem_pkg.sv
// ----------------------------------------------------------------------------
// nios_fprint_ocimem_pkg
// Shared definitions for the fingerprinting Nios II debug OCI memory
// controller: the controller state encoding and the bit positions of the
// fields carried in the 38-bit JTAG `jdo` word.
// No ports (package).
// ----------------------------------------------------------------------------
package nios_fprint_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_WR_ISSUE = 2'd3
    } ocimem_state_t;

    localparam int JDO_W        = 38;
    localparam int DATA_W       = 32;
    localparam int JDO_RD_BIT   = 34;  // address command also requests a read
    localparam int JDO_CLR_BIT  = 35;  // address command clears cmd_overrun
    localparam int JDO_ADDR_LSB = 17;  // word address field LSB
    localparam int JDO_DATA_LSB = 3;   // 32-bit write data field LSB

endpackage

// File: rtl/nios_fprint_ocimem_ram.sv
// ----------------------------------------------------------------------------
// nios_fprint_ocimem_ram
// Single-port 2^ADDR_W x 32 debug RAM with per-byte write enables and a
// registered read output (one cycle latency, read returns pre-write data).
// Contents are never reset.
// Ports:
//   clk      in   clock
//   i_addr   in   word address
//   i_we     in   write enable
//   i_be     in   byte lane enables for writes
//   i_wdata  in   write data
//   o_q      out  registered read data of the address presented last cycle
// ----------------------------------------------------------------------------
module nios_fprint_ocimem_ram
    import nios_fprint_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_we,
    input  logic [3:0]          i_be,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_q;

    // Byte-lane writes plus registered read of the same address.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        r_q <= r_mem[i_addr];
    end

    assign o_q = r_q;

endmodule

// File: rtl/nios_fprint_cpu_ocimem_ctrl.sv
// ----------------------------------------------------------------------------
// nios_fprint_cpu_ocimem_ctrl
// Debug OCI memory controller. Executes JTAG-initiated reads/writes of the
// debug RAM (driven by the sysclk-stage take_* strobes and jdo) and shares the
// single RAM port with the CPU Avalon slave. JTAG owns the RAM in its issue
// cycle; a CPU access in that cycle is stalled for one cycle.
//
// Build option: OCIMEM_WRITE_PROTECT_EN -- when defined, CPU writes with
// av_debugaccess=0 are accepted but discarded. JTAG writes are unaffected.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   jdo[37:0]                  JTAG data word (valid with a take_* strobe)
//   take_action_ocimem_a       address load (+ optional read / overrun clear)
//   take_action_ocimem_b       write data load and write
//   take_no_action_ocimem_a    readback consumed: increment address and read
//   av_address/read/write/writedata/byteenable/debugaccess  CPU slave request
//   av_readdata, av_readdatavalid, av_waitrequest           CPU slave response
//   MonDReg, MonAReg           JTAG data / address registers
//   jtag_busy                  JTAG operation in flight
//   cmd_overrun                sticky: a strobe was dropped
// ----------------------------------------------------------------------------
module nios_fprint_cpu_ocimem_ctrl
    import nios_fprint_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [JDO_W-1:0]    jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic                take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0]   av_address,
    input  logic                av_read,
    input  logic                av_write,
    input  logic [DATA_W-1:0]   av_writedata,
    input  logic [3:0]          av_byteenable,
    input  logic                av_debugaccess,
    output logic [DATA_W-1:0]   av_readdata,
    output logic                av_readdatavalid,
    output logic                av_waitrequest,
    output logic [DATA_W-1:0]   MonDReg,
    output logic [ADDR_W-1:0]   MonAReg,
    output logic                jtag_busy,
    output logic                cmd_overrun
);

    localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    ocimem_state_t       r_state;
    ocimem_state_t       w_next_state;
    logic [DATA_W-1:0]   r_mon_d;
    logic [ADDR_W-1:0]   r_mon_a;
    logic                r_overrun;
    logic                r_rdvalid;

    logic                w_idle;
    logic                w_take_a;
    logic                w_take_b;
    logic                w_take_na;
    logic                w_drop;
    logic                w_jtag_issue;
    logic                w_cpu_wr_ok;

    logic [ADDR_W-1:0]   w_ram_addr;
    logic                w_ram_we;
    logic [3:0]          w_ram_be;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic [DATA_W-1:0]   w_ram_q;

`ifdef OCIMEM_WRITE_PROTECT_EN
    assign w_cpu_wr_ok = av_debugaccess;
`else
    assign w_cpu_wr_ok = 1'b1;
`endif

    // jdo bits outside the address/data/flag fields carry nothing here.
    logic w_unused_bits;
    assign w_unused_bits = ^{jdo[JDO_W-1:JDO_CLR_BIT+1], jdo[JDO_DATA_LSB-1:0], av_debugaccess};

    // Strobe arbitration: _a beats _b beats no_action_a; only IDLE accepts.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_take_a  = w_idle & take_action_ocimem_a;
    assign w_take_b  = w_idle & ~take_action_ocimem_a & take_action_ocimem_b;
    assign w_take_na = w_idle & ~take_action_ocimem_a & ~take_action_ocimem_b
                       & take_no_action_ocimem_a;
    assign w_drop    = w_idle
                       ? ((take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                          | (take_action_ocimem_b & take_no_action_ocimem_a))
                       : (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (w_take_a && jdo[JDO_RD_BIT]) begin
                    w_next_state = ST_RD_ISSUE;
                end else if (w_take_b) begin
                    w_next_state = ST_WR_ISSUE;
                end else if (w_take_na) begin
                    w_next_state = ST_RD_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD_ISSUE: w_next_state = ST_RD_WAIT;
            ST_RD_WAIT:  w_next_state = ST_IDLE;
            ST_WR_ISSUE: w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: RAM port mux (JTAG in its issue cycle, otherwise CPU).
    always_comb begin
        w_ram_addr  = av_address;
        w_ram_we    = 1'b0;
        w_ram_be    = av_byteenable;
        w_ram_wdata = av_writedata;
        case (r_state)
            ST_RD_ISSUE: begin
                w_ram_addr = r_mon_a;
            end
            ST_WR_ISSUE: begin
                // A reset landing on the write cycle abandons the write.
                w_ram_addr  = r_mon_a;
                w_ram_we    = ~reset;
                w_ram_be    = 4'hF;
                w_ram_wdata = r_mon_d;
            end
            default: begin
                // Protected writes are still accepted, just not performed.
                w_ram_we = av_write & w_cpu_wr_ok & ~reset;
            end
        endcase
    end

    assign w_jtag_issue   = (r_state == ST_RD_ISSUE) | (r_state == ST_WR_ISSUE);
    assign av_waitrequest = (av_read | av_write) & w_jtag_issue;
    assign jtag_busy      = ~w_idle;

    // JTAG registers, overrun flag and CPU read-valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mon_d   <= 32'h0;
            r_mon_a   <= {ADDR_W{1'b0}};
            r_overrun <= 1'b0;
            r_rdvalid <= 1'b0;
        end else begin
            if (w_take_a) begin
                r_mon_a <= jdo[JDO_ADDR_LSB +: ADDR_W];
            end else if (w_take_na || (r_state == ST_WR_ISSUE)) begin
                r_mon_a <= r_mon_a + A_ONE;  // wraps modulo 2^ADDR_W
            end

            if (w_take_b) begin
                r_mon_d <= jdo[JDO_DATA_LSB +: DATA_W];
            end else if (r_state == ST_RD_WAIT) begin
                r_mon_d <= w_ram_q;
            end

            // A dropped strobe in the clearing cycle still leaves the flag set.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (w_take_a && jdo[JDO_CLR_BIT]) begin
                r_overrun <= 1'b0;
            end

            r_rdvalid <= av_read & ~w_jtag_issue;
        end
    end

    assign MonDReg          = r_mon_d;
    assign MonAReg          = r_mon_a;
    assign cmd_overrun      = r_overrun;
    assign av_readdatavalid = r_rdvalid;
    assign av_readdata      = r_rdvalid ? w_ram_q : 32'h0;

    nios_fprint_ocimem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

endmodule

// File: tb/tb_nios_fprint_cpu_ocimem_ctrl.sv
module tb_nios_fprint_cpu_ocimem_ctrl;

    localparam int AW = 8;
`ifdef OCIMEM_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [37:0]   jdo;
    logic          ta_a, ta_b, tna_a;
    logic [AW-1:0] av_address;
    logic          av_read, av_write, av_debugaccess;
    logic [31:0]   av_writedata;
    logic [3:0]    av_byteenable;
    logic [31:0]   av_readdata, MonDReg;
    logic          av_readdatavalid, av_waitrequest, jtag_busy, cmd_overrun;
    logic [AW-1:0] MonAReg;

    nios_fprint_cpu_ocimem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
        .take_no_action_ocimem_a(tna_a),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_debugaccess(av_debugaccess),
        .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
        .av_waitrequest(av_waitrequest),
        .MonDReg(MonDReg), .MonAReg(MonAReg),
        .jtag_busy(jtag_busy), .cmd_overrun(cmd_overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (timeline of scheduled events) -----
    logic [31:0] m_mem [0:255];
    logic [7:0]  m_a;
    logic [31:0] m_d, m_rd_val, m_rdata;
    logic        m_ovr, m_rdv, m_is_read;
    logic        m_live = 1'b0;
    int          cyc = 0;
    int          m_issue_at = -1, m_capture_at = -1, m_busy_end = -1;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic sched_read();
        m_is_read    = 1'b1;
        m_issue_at   = cyc + 1;
        m_capture_at = cyc + 2;
        m_busy_end   = cyc + 2;
    endtask

    task automatic model_step();
        logic jtag_now, idle;
        if (reset) begin
            m_a = 8'h0; m_d = 32'h0; m_ovr = 1'b0; m_rdv = 1'b0; m_rdata = 32'h0;
            m_issue_at = -1; m_capture_at = -1; m_busy_end = -1;
            m_live = 1'b1;
        end else begin
            jtag_now = (cyc == m_issue_at);
            idle     = (cyc > m_busy_end);
            if (jtag_now && m_is_read)  m_rd_val = m_mem[m_a];
            if (jtag_now && !m_is_read) begin
                m_mem[m_a] = m_d;
                m_a = m_a + 8'd1;
            end
            if (cyc == m_capture_at) m_d = m_rd_val;
            m_rdv   = !jtag_now && av_read;
            m_rdata = m_rdv ? m_mem[av_address] : 32'h0;
            if (!jtag_now && av_write && (!WP || av_debugaccess))
                m_mem[av_address] = merge(m_mem[av_address], av_writedata, av_byteenable);
            if (idle) begin
                if (ta_a) begin
                    m_a = jdo[24:17];
                    if (jdo[35]) m_ovr = 1'b0;
                    if (jdo[34]) sched_read();
                    if (ta_b || tna_a) m_ovr = 1'b1;
                end else if (ta_b) begin
                    m_d = jdo[34:3];
                    m_is_read  = 1'b0;
                    m_issue_at = cyc + 1;
                    m_busy_end = cyc + 1;
                    if (tna_a) m_ovr = 1'b1;
                end else if (tna_a) begin
                    m_a = m_a + 8'd1;
                    sched_read();
                end
            end else if (ta_a || ta_b || tna_a) begin
                m_ovr = 1'b1;
            end
        end
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("MonDReg",     MonDReg,                  m_d);
                chk("MonAReg",     {24'h0, MonAReg},         {24'h0, m_a});
                chk("jtag_busy",   {31'h0, jtag_busy},       {31'h0, (cyc <= m_busy_end)});
                chk("cmd_overrun", {31'h0, cmd_overrun},     {31'h0, m_ovr});
                chk("waitrequest", {31'h0, av_waitrequest},
                    {31'h0, ((av_read || av_write) && (cyc == m_issue_at))});
                chk("rdvalid",     {31'h0, av_readdatavalid}, {31'h0, m_rdv});
                chk("readdata",    av_readdata,              m_rdata);
            end
        end
    end

    // ---------------- directed stimulus ------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] ad, input logic rd, input logic clr);
        logic [37:0] j;
        j = 38'h0;
        j[24:17] = ad;
        j[34] = rd;
        j[35] = clr;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j = 38'h0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic jtag_a(input logic [7:0] ad, input logic rd, input logic clr);
        jdo = mk_a(ad, rd, clr); ta_a = 1'b1;
        tick();
        ta_a = 1'b0; jdo = 38'h0;
    endtask

    task automatic jtag_b(input logic [31:0] d);
        jdo = mk_b(d); ta_b = 1'b1;
        tick();
        ta_b = 1'b0; jdo = 38'h0;
    endtask

    task automatic cpu_wr(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] be,
                          input logic dbg);
        av_address = ad; av_writedata = d; av_byteenable = be; av_debugaccess = dbg;
        av_write = 1'b1;
        tick();
        av_write = 1'b0; av_byteenable = 4'hF; av_debugaccess = 1'b1;
    endtask

    task automatic cpu_rd_chk(input string nm, input logic [7:0] ad, input logic [31:0] exp);
        av_address = ad; av_read = 1'b1;
        tick();
        av_read = 1'b0;
        chk({nm, "_valid"}, {31'h0, av_readdatavalid}, 32'h1);
        chk(nm, av_readdata, exp);
    endtask

    logic [31:0] stream_exp [3];

    initial begin
        reset = 1'b1; jdo = 38'h0; ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
        av_address = 8'h0; av_read = 1'b0; av_write = 1'b0; av_writedata = 32'h0;
        av_byteenable = 4'hF; av_debugaccess = 1'b1;
        stream_exp[0] = 32'h0000_1111;
        stream_exp[1] = 32'h0000_2222;
        stream_exp[2] = 32'h0000_3333;
        tick(); tick();
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_MonAReg", {24'h0, MonAReg}, 32'h0);
        chk("rst_busy", {31'h0, jtag_busy}, 32'h0);
        chk("rst_overrun", {31'h0, cmd_overrun}, 32'h0);
        chk("rst_rdvalid", {31'h0, av_readdatavalid}, 32'h0);
        reset = 1'b0;

        // Seed the RAM through the CPU port.
        cpu_wr(8'h05, 32'hDEAD_BEEF, 4'hF, 1'b1);
        cpu_wr(8'h11, 32'h0000_1111, 4'hF, 1'b1);
        cpu_wr(8'h12, 32'h0000_2222, 4'hF, 1'b1);
        cpu_wr(8'h13, 32'h0000_3333, 4'hF, 1'b1);
        cpu_wr(8'hFF, 32'hCAFE_F00D, 4'hF, 1'b1);
        cpu_wr(8'h20, 32'h5566_7788, 4'hF, 1'b1);
        cpu_wr(8'h30, 32'h3030_3030, 4'hF, 1'b1);
        cpu_rd_chk("cpu_rd_05", 8'h05, 32'hDEAD_BEEF);

        // JTAG read of 0x05.
        jtag_a(8'h05, 1'b1, 1'b0);
        chk("rd_busy_n1", {31'h0, jtag_busy}, 32'h1);
        tick(); tick();
        chk("rd_MonDReg", MonDReg, 32'hDEAD_BEEF);
        chk("rd_MonAReg", {24'h0, MonAReg}, 32'h05);
        chk("rd_busy_done", {31'h0, jtag_busy}, 32'h0);

        // JTAG write at 0xFF, address wraps to 0.
        jtag_a(8'hFF, 1'b0, 1'b0);
        jtag_b(32'h1234_5678);
        tick();
        chk("wr_wrap_MonAReg", {24'h0, MonAReg}, 32'h00);
        cpu_rd_chk("wr_ram_FF", 8'hFF, 32'h1234_5678);

        // Streaming reads via take_no_action, 4 cycles apart.
        jtag_a(8'h10, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tna_a = 1'b1;
            tick();
            tna_a = 1'b0;
            tick(); tick();
            chk("stream_MonDReg", MonDReg, stream_exp[k]);
            chk("stream_MonAReg", {24'h0, MonAReg}, 32'h11 + k);
            tick();
        end

        // JTAG and CPU write the same word in the same cycle.
        jtag_a(8'h20, 1'b0, 1'b0);
        jtag_b(32'hAAAA_BBBB);
        av_address = 8'h20; av_writedata = 32'h1111_2222; av_byteenable = 4'b0011;
        av_write = 1'b1;
        #1;
        chk("coll_wait_issue", {31'h0, av_waitrequest}, 32'h1);
        tick();
        chk("coll_wait_after", {31'h0, av_waitrequest}, 32'h0);
        tick();
        av_write = 1'b0; av_byteenable = 4'hF;
        cpu_rd_chk("coll_final", 8'h20, 32'hAAAA_2222);

        // _a and _b together: read wins, write dropped, overrun set then cleared.
        jdo = mk_a(8'h05, 1'b1, 1'b0); ta_a = 1'b1; ta_b = 1'b1;
        tick();
        ta_a = 1'b0; ta_b = 1'b0; jdo = 38'h0;
        tick(); tick();
        chk("both_MonDReg", MonDReg, 32'hDEAD_BEEF);
        chk("both_overrun", {31'h0, cmd_overrun}, 32'h1);
        cpu_rd_chk("both_ram_05", 8'h05, 32'hDEAD_BEEF);
        jtag_a(8'h05, 1'b0, 1'b1);
        chk("clr_overrun", {31'h0, cmd_overrun}, 32'h0);

        // Strobe while busy is dropped.
        jtag_a(8'h05, 1'b1, 1'b0);
        jtag_b(32'h7777_7777);
        tick();
        chk("busy_drop_overrun", {31'h0, cmd_overrun}, 32'h1);
        chk("busy_drop_MonDReg", MonDReg, 32'hDEAD_BEEF);
        jtag_a(8'h05, 1'b0, 1'b1);

        // Reset during RD_WAIT.
        jtag_a(8'h05, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_rdwait_MonDReg", MonDReg, 32'h0);
        chk("rst_rdwait_busy", {31'h0, jtag_busy}, 32'h0);

        // Reset during WR_ISSUE: write is not performed.
        jtag_a(8'h30, 1'b0, 1'b0);
        jtag_b(32'hFFFF_0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_wr_MonAReg", {24'h0, MonAReg}, 32'h0);
        cpu_rd_chk("rst_wr_ram_30", 8'h30, 32'h3030_3030);

        // Non-debug CPU write (discarded only in the write-protected build).
        cpu_wr(8'h12, 32'h0BAD_0BAD, 4'hF, 1'b0);
        cpu_rd_chk("wp_ram_12", 8'h12, WP ? 32'h0000_2222 : 32'h0BAD_0BAD);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nios_fprint_cpu_ocimem_ctrl.md
# nios_fprint_cpu_ocimem_ctrl

Debug-side on-chip memory (OCI memory) controller for each fingerprinting Nios II core. Consumes the `jdo` word and the `take_action_ocimem_*` / `take_no_action_ocimem_a` strobes from the JTAG debug module's sysclk stage. It performs JTAG-initiated reads and writes into a 32-bit debug RAM while arbitrating against the CPU's Avalon slave accesses. It returns `MonDReg`, which the JTAG tck stage shifts back to the host.

## Interface
Parameters:
- `ADDR_W`, 8 — word-address width of the debug RAM (2^ADDR_W × 32 bits).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  JTAG data word, valid in any cycle a `take_*` strobe is high.
- `take_action_ocimem_a`  in  1  address/read command.
- `take_action_ocimem_b`  in  1  write-data command.
- `take_no_action_ocimem_a`  in  1  readback consumed; stream the next read.
- `av_address`  in  ADDR_W  CPU word address.
- `av_read` / `av_write`  in  1  CPU read or write request.
- `av_writedata`  in  32  CPU write data.
- `av_byteenable`  in  4  CPU byte lanes.
- `av_debugaccess`  in  1  CPU access is debug-privileged.
- `av_readdata`  out  32  CPU read data.
- `av_readdatavalid`  out  1  CPU read data valid.
- `av_waitrequest`  out  1  CPU stall.
- `MonDReg`  out  32  JTAG data register.
- `MonAReg`  out  ADDR_W  JTAG address register.
- `jtag_busy`  out  1  JTAG operation in flight.
- `cmd_overrun`  out  1  sticky flag: a command arrived while busy.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE.
- `take_action_ocimem_a` in IDLE:
  - `MonAReg <= jdo[ADDR_W+16:17]`.
  - If `jdo[34]` is set, go to RD_ISSUE; otherwise stay in IDLE.
  - If `jdo[35]` is set, clear `cmd_overrun`.
- `take_action_ocimem_b` in IDLE: `MonDReg <= jdo[34:3]`, go to WR_ISSUE.
- `take_no_action_ocimem_a` in IDLE: `MonAReg <= MonAReg+1`, go to RD_ISSUE.
- RD_ISSUE: drive a RAM read at `MonAReg`, go to RD_WAIT.
- RD_WAIT: `MonDReg <= ram_q`, go to IDLE.
- WR_ISSUE: write `MonDReg` to `RAM[MonAReg]` with all byte lanes, then `MonAReg <= MonAReg+1`, go to IDLE.
- Priority when strobes coincide: `_a` over `_b` over `no_action_a`. The losing strobes are dropped and set `cmd_overrun`.
- Any strobe arriving outside IDLE is dropped and sets `cmd_overrun`.
- Address arithmetic is modulo 2^ADDR_W: `MonAReg` wraps from all-ones to 0.
- CPU side:
  - `av_waitrequest = (av_read|av_write) & (state==RD_ISSUE | state==WR_ISSUE)`. JTAG has absolute priority in its issue cycle.
  - An accepted CPU read asserts `av_readdatavalid` with `av_readdata` on the next cycle.
  - CPU writes honour `av_byteenable`.
- `jtag_busy = (state != IDLE)`.
- Reset:
  - State → IDLE; `MonDReg`, `MonAReg`, `av_readdata` → 0; `av_readdatavalid`, `cmd_overrun` → 0.
  - RAM contents are not cleared.
  - Reset in mid-operation abandons the operation. A write in WR_ISSUE coincident with `reset` is not performed.

## Timing
- JTAG read: strobe at cycle N → `MonDReg` updated at the end of N+2. `jtag_busy` is high in N+1 and N+2.
- JTAG write: strobe at N → RAM written and `MonAReg` incremented at the end of N+1.
- CPU read: accepted at N → `av_readdatavalid` in N+1.
- CPU stall is at most 1 cycle per JTAG operation.
- A JTAG write and a CPU write to the same address in one cycle: JTAG writes at N, CPU stalls and writes at N+1. The CPU value is final.
- The RAM is registered-output, single-port, with 1-cycle read latency.

## Configuration
- `OCIMEM_WRITE_PROTECT_EN` defined:
  - A CPU write with `av_debugaccess=0` is accepted (no stall beyond arbitration) but discarded.
  - JTAG writes are unaffected.
- Not defined: all CPU writes take effect; `av_debugaccess` is ignored.

## Structure
- Shared package `nios_fprint_ocimem_pkg`:
  - State enum.
  - `jdo` field constants: `JDO_RD_BIT=34`, `JDO_CLR_BIT=35`, `JDO_ADDR_LSB=17`, `JDO_DATA_LSB=3`.
- Sub-module `nios_fprint_ocimem_ram`: single-port 2^ADDR_W × 32 RAM with byte enables and registered output. The controller owns the address/write mux feeding it.

## Test plan
- Seed RAM[0x05]=0xDEADBEEF; `take_action_ocimem_a` with address 0x05 and `jdo[34]=1` → `MonDReg`=0xDEADBEEF two cycles later, `MonAReg`=0x05.
- `take_action_ocimem_b` with data 0x12345678 at `MonAReg`=0xFF → RAM[0xFF]=0x12345678, `MonAReg` wraps to 0x00.
- Pulse `take_no_action_ocimem_a` three times, 4 cycles apart, from `MonAReg`=0x10 → `MonDReg` returns RAM[0x11], RAM[0x12], RAM[0x13] in order.
- CPU `av_write` with `av_byteenable`=4'b0011 to the same address and same cycle as a JTAG write → `av_waitrequest`=1 for one cycle; final word = JTAG data upper half, CPU data lower half.
- `take_action_ocimem_a` and `_b` in the same cycle → address loaded, read performed, write dropped, `cmd_overrun`=1. Next `_a` with `jdo[35]=1` clears the flag.
- `reset` asserted during RD_WAIT → next cycle `MonDReg`=0, `jtag_busy`=0; with `OCIMEM_WRITE_PROTECT_EN`, a CPU write with `av_debugaccess=0` leaves RAM unchanged.
